time_keeper: RTL
================

Name: time_keeper

Overview:
- Consumes the divided clock produced by the time divider stage and keeps time of day as BCD HH:MM:SS, 24-hour.
- The divided clock is treated as a data level sampled in the i_CLK domain, never as a clock.
- Provides a set mode so the user can increment hours, minutes or seconds individually.
- Feeds the display/scan stage downstream.

Parameters:
- TICKS_PER_SEC, 1, number of rising edges of i_TICK that make one second (1..255).
- PS_W, 8, prescaler counter width; must hold TICKS_PER_SEC-1.

Ports:
- i_CLK  input  1  system clock; all state is on its rising edge.
- i_RST  input  1  asynchronous, active-high reset.
- i_TICK  input  1  divided clock level from the time divider, synchronous to i_CLK.
- i_RUN  input  1  1 = count, 0 = pause (state held).
- i_SET_EN  input  1  1 = set mode; timekeeping frozen.
- i_SET_SEL  input  2  field select: 00 seconds, 01 minutes, 10 hours, 11 none.
- i_INC  input  1  debounced increment button level; acts on its rising edge.
- o_SEC  output  8  BCD seconds {tens[7:4], ones[3:0]}, 00..59.
- o_MIN  output  8  BCD minutes, 00..59.
- o_HOUR  output  8  BCD hours, 00..23.
- o_SEC_PULSE  output  1  one-cycle pulse on each counted second.
- o_DAY_PULSE  output  1  one-cycle pulse on the 23:59:59 -> 00:00:00 rollover.

Behaviour:
- Reset (async, i_RST=1): all outputs 0; prescaler 0; tick_d=0; inc_d=0. State is held while reset stays high.
- Edge detect:
  - tick_d and inc_d are registers.
  - tick_rise = i_TICK & ~tick_d.
  - inc_rise = i_INC & ~inc_d.
  - tick_d and inc_d update every cycle, in all modes.
- Run mode (i_SET_EN=0, i_RUN=1), on tick_rise:
  - If prescaler==TICKS_PER_SEC-1: prescaler <= 0 and a second is counted.
  - Otherwise prescaler increments.
- Second counted:
  - Seconds +1 in BCD: ones 9 -> 0 carries into tens; 59 -> 00 carries into minutes.
  - Minutes follow the same rule; 59 -> 00 carries into hours.
  - Hours 23 -> 00 wraps.
  - The whole carry chain resolves in the same cycle.
  - o_SEC_PULSE=1 for that cycle.
  - o_DAY_PULSE=1 for that cycle only when the pre-update value was 23:59:59.
- Latency: with TICKS_PER_SEC=1, outputs change on the first i_CLK edge after i_TICK is first sampled high, i.e. 1 cycle after the rise is visible. Pulses are registered and coincide with the new value.
- Pause (i_RUN=0, i_SET_EN=0):
  - Time and prescaler are held.
  - tick_rise is ignored; missed ticks are not accumulated.
  - Pulses are 0.
- Set mode (i_SET_EN=1): dominates i_RUN and tick_rise.
  - Prescaler is forced to 0.
  - On inc_rise, the selected field increments modulo its maximum (59, 59 or 23) with no carry to the next field. SEL=11 does nothing.
  - Pulses are 0 in set mode.
- Leaving set mode: counting resumes with prescaler 0; the first second arrives after TICKS_PER_SEC further tick rises.
- i_INC held high gives exactly one increment. i_TICK held high gives exactly one rise.
- Simultaneous tick_rise and inc_rise in run mode: inc_rise is ignored and tick_rise is processed.
- BCD invariant: no digit ever leaves 0..9; tens digits never exceed 5 (sec, min) or 2 (hour). Hours tens=2 wraps at ones=3.

Decomposition:
- Package time_pkg holds:
  - SEL_SEC=2'b00, SEL_MIN=2'b01, SEL_HOUR=2'b10, SEL_NONE=2'b11.
  - MAX_SEC=8'h59, MAX_MIN=8'h59, MAX_HOUR=8'h23 (BCD).
- Sub-module bcd_mod_counter:
  - Two-digit BCD counter with a MAX parameter.
  - Inputs: clock, async reset, inc.
  - Outputs: value, wrap (combinational, true when value==MAX and inc).
  - Instantiated three times, with the wrap outputs chained.
  - In set mode, inc comes from the set logic and the chain is gated off.
- Top level holds the edge detectors, prescaler, mode logic and pulse registers.

Test Plan:
- Reset mid-count at 12:34:56: assert i_RST asynchronously between clock edges -> all outputs 00 immediately; they stay 00 while i_RST=1; counting restarts from 00:00:00.
- TICKS_PER_SEC=1, i_RUN=1, 60 tick rises from 00:00:58 -> 00:01:58; o_SEC_PULSE count=60; o_DAY_PULSE never asserted.
- Preload 23:59:59 via set mode, exit, one tick rise -> 00:00:00; o_DAY_PULSE and o_SEC_PULSE high for exactly that one cycle.
- TICKS_PER_SEC=4: 7 tick rises -> o_SEC=01. i_TICK held high for 20 cycles -> only one rise counted.
- Set mode, SEL=00, at 00:00:59: one i_INC press -> 00:00:00 with minutes unchanged. SEL=10 at 23 -> 00. SEL=11 -> no change. Holding i_INC 50 cycles gives a single increment.
- i_RUN=0 with 10 tick rises -> time unchanged. tick_rise and inc_rise in the same cycle in run mode -> only the second advances.

Source files
------------

// File: rtl/time_keeper_pkg.sv
//------------------------------------------------------------------------------
// Module  : time_pkg
// Brief   : Shared field-select codes and BCD limits for the time keeper.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package time_pkg;

    localparam logic [1:0] SEL_SEC  = 2'b00;
    localparam logic [1:0] SEL_MIN  = 2'b01;
    localparam logic [1:0] SEL_HOUR = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    localparam logic [7:0] MAX_SEC  = 8'h59;
    localparam logic [7:0] MAX_MIN  = 8'h59;
    localparam logic [7:0] MAX_HOUR = 8'h23;

endpackage

`default_nettype wire

// File: rtl/time_keeper_counter.sv
//------------------------------------------------------------------------------
// Module  : bcd_mod_counter
// Brief   : Two-digit BCD counter wrapping to 00 after MAX, with carry-out.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_mod_counter #(
    parameter logic [7:0] MAX = 8'h59
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_inc,
    output logic [7:0] o_value,
    output logic       o_wrap
);

    logic [7:0] r_value;
    logic [7:0] w_next;

    // Ones roll into tens at 9; the whole value returns to 00 at MAX.
    always_comb begin
        w_next = r_value;
        if (r_value == MAX)
            w_next = 8'h00;
        else if (r_value[3:0] == 4'd9)
            w_next = {r_value[7:4] + 4'd1, 4'd0};
        else
            w_next = {r_value[7:4], r_value[3:0] + 4'd1};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_value <= 8'h00;
        else if (i_inc)
            r_value <= w_next;
    end

    assign o_value = r_value;
    assign o_wrap  = i_inc && (r_value == MAX);

endmodule

`default_nettype wire

// File: rtl/time_keeper.sv
//------------------------------------------------------------------------------
// Module  : time_keeper
// Brief   : 24-hour BCD time of day driven by a sampled divided-clock level.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module time_keeper
    import time_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 1,
    parameter int unsigned PS_W          = 8
) (
    input  logic       i_CLK,
    input  logic       i_RST,
    input  logic       i_TICK,
    input  logic       i_RUN,
    input  logic       i_SET_EN,
    input  logic [1:0] i_SET_SEL,
    input  logic       i_INC,
    output logic [7:0] o_SEC,
    output logic [7:0] o_MIN,
    output logic [7:0] o_HOUR,
    output logic       o_SEC_PULSE,
    output logic       o_DAY_PULSE
);

    localparam logic [PS_W-1:0] c_PS_LAST = PS_W'(TICKS_PER_SEC - 1);

    logic            r_tick_d;
    logic            r_inc_d;
    logic [PS_W-1:0] r_ps;
    logic            r_sec_pulse;
    logic            r_day_pulse;

    logic w_tick_rise;
    logic w_inc_rise;
    logic w_advance;
    logic w_count;
    logic w_sec_inc;
    logic w_min_inc;
    logic w_hour_inc;
    logic w_sec_wrap;
    logic w_min_wrap;
    logic w_hour_wrap;

    assign w_tick_rise = i_TICK & ~r_tick_d;
    assign w_inc_rise  = i_INC & ~r_inc_d;

    // Set mode outranks run; a tick rise only matters while running.
    assign w_advance = ~i_SET_EN & i_RUN & w_tick_rise;
    assign w_count   = w_advance & (r_ps == c_PS_LAST);

    // In set mode each field is driven alone and the carry chain is cut.
    assign w_sec_inc  = i_SET_EN ? (w_inc_rise && i_SET_SEL == SEL_SEC)  : w_count;
    assign w_min_inc  = i_SET_EN ? (w_inc_rise && i_SET_SEL == SEL_MIN)  : w_sec_wrap;
    assign w_hour_inc = i_SET_EN ? (w_inc_rise && i_SET_SEL == SEL_HOUR) : w_min_wrap;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            r_tick_d    <= 1'b0;
            r_inc_d     <= 1'b0;
            r_ps        <= '0;
            r_sec_pulse <= 1'b0;
            r_day_pulse <= 1'b0;
        end else begin
            r_tick_d    <= i_TICK;
            r_inc_d     <= i_INC;
            r_sec_pulse <= w_count;
            r_day_pulse <= w_count & w_hour_wrap;
            if (i_SET_EN)
                r_ps <= '0;
            else if (w_advance)
                r_ps <= (r_ps == c_PS_LAST) ? '0 : r_ps + 1'b1;
        end
    end

    bcd_mod_counter #(.MAX(MAX_SEC)) u_sec (
        .i_clk   (i_CLK),
        .i_rst   (i_RST),
        .i_inc   (w_sec_inc),
        .o_value (o_SEC),
        .o_wrap  (w_sec_wrap)
    );

    bcd_mod_counter #(.MAX(MAX_MIN)) u_min (
        .i_clk   (i_CLK),
        .i_rst   (i_RST),
        .i_inc   (w_min_inc),
        .o_value (o_MIN),
        .o_wrap  (w_min_wrap)
    );

    bcd_mod_counter #(.MAX(MAX_HOUR)) u_hour (
        .i_clk   (i_CLK),
        .i_rst   (i_RST),
        .i_inc   (w_hour_inc),
        .o_value (o_HOUR),
        .o_wrap  (w_hour_wrap)
    );

    assign o_SEC_PULSE = r_sec_pulse;
    assign o_DAY_PULSE = r_day_pulse;

endmodule

`default_nettype wire
